// File: rtl/snes_bus_respond_if.sv
// snes_bus_respond_if
//   Groups the SNES B-bus pins and the host-side FIFO/receive handshake of
//   snes_bus_respond into one bundle.
//   slave  : the responder (drives D_out/D_oe, tx_ready, rx_data/rx_valid)
//   master : the SNES side plus the host (drives PA, strobes, D_in, tx_*)
//   PA       8  raw B-bus address
//   PARD_n   1  raw read strobe (active low)
//   PAWR_n   1  raw write strobe (active low)
//   D_in     8  raw data bus, input side
//   D_out    8  data driven to the SNES
//   D_oe     1  enable for the external data-bus buffer
//   tx_data  8  host byte to queue
//   tx_valid 1  host push request
//   tx_ready 1  FIFO accepts a push this cycle
//   rx_data  8  last byte written by the SNES to the data register
//   rx_valid 1  one-cycle pulse when rx_data updates
interface snes_bus_respond_if;
  logic [7:0] PA;
  logic       PARD_n;
  logic       PAWR_n;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport slave (
    input  PA, PARD_n, PAWR_n, D_in, tx_data, tx_valid,
    output D_out, D_oe, tx_ready, rx_data, rx_valid
  );

  modport master (
    output PA, PARD_n, PAWR_n, D_in, tx_data, tx_valid,
    input  D_out, D_oe, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/snes_bus_respond.sv
// snes_bus_respond
//   B-bus register responder. Two registers are decoded on the SNES B-bus:
//   BASE_ADDR is status (read) / control (write, bit0 = flush), BASE_ADDR+1
//   is data (read pops the host-fed transmit FIFO, write produces an rx
//   event). All SNES pins are asynchronous and are synchronised here.
//   clk   : 40 MHz board clock
//   rst_n : asynchronous active-low reset
//   bus   : snes_bus_respond_if.slave (SNES pins + host tx/rx handshake)
module snes_bus_respond #(
  parameter logic [7:0] BASE_ADDR  = 8'hF8,
  parameter int         FIFO_DEPTH = 8      // 2, 4 or 8
) (
  input  logic               clk,
  input  logic               rst_n,
  snes_bus_respond_if.slave  bus
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0]      DATA_ADDR = BASE_ADDR + 8'd1;   // wraps in 8 bits
  localparam logic [3:0]      DEPTH4    = 4'(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_LAST  = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Synchroniser chains; strobe chains idle high so reset never fakes an edge.
  logic [7:0] pa_s1_q, pa_s_q;
  logic [7:0] din_s1_q, din_s_q;
  logic       pard_s1_q, pard_s_q, pard_s3_q;
  logic       pawr_s1_q, pawr_s_q, pawr_s3_q;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;

  // FSM state and registered outputs
  state_e     state_q;
  logic       sel_q;
  logic [7:0] wr_byte_q;
  logic [7:0] d_out_q;
  logic       d_oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  // Decoded events
  logic       pard_fall, pard_rise, pawr_fall, pawr_rise;
  logic       addr_hit, addr_sel;
  logic       fifo_empty, fifo_full;
  logic       flush_cycle, push, pop;
  logic [7:0] status_byte, head_byte;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Two-flop synchronisers plus a third strobe flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_s1_q   <= 8'h00;
      pa_s_q    <= 8'h00;
      din_s1_q  <= 8'h00;
      din_s_q   <= 8'h00;
      pard_s1_q <= 1'b1;
      pard_s_q  <= 1'b1;
      pard_s3_q <= 1'b1;
      pawr_s1_q <= 1'b1;
      pawr_s_q  <= 1'b1;
      pawr_s3_q <= 1'b1;
    end else begin
      pa_s1_q   <= bus.PA;
      pa_s_q    <= pa_s1_q;
      din_s1_q  <= bus.D_in;
      din_s_q   <= din_s1_q;
      pard_s1_q <= bus.PARD_n;
      pard_s_q  <= pard_s1_q;
      pard_s3_q <= pard_s_q;
      pawr_s1_q <= bus.PAWR_n;
      pawr_s_q  <= pawr_s1_q;
      pawr_s3_q <= pawr_s_q;
    end
  end

  // Edge detection, address decode and FIFO handshake terms.
  always_comb begin
    pard_fall   = !pard_s_q &&  pard_s3_q;
    pard_rise   =  pard_s_q && !pard_s3_q;
    pawr_fall   = !pawr_s_q &&  pawr_s3_q;
    pawr_rise   =  pawr_s_q && !pawr_s3_q;
    addr_sel    = (pa_s_q == DATA_ADDR);
    addr_hit    = (pa_s_q == BASE_ADDR) || addr_sel;
    fifo_empty  = (count_q == 4'd0);
    fifo_full   = (count_q == DEPTH4);
    // A control write with bit0 set empties the FIFO on the strobe's rising edge.
    flush_cycle = (state_q == ST_WRITE) && pawr_rise && !sel_q && wr_byte_q[0];
    push        = bus.tx_valid && !fifo_full && !flush_cycle;
    pop         = (state_q == ST_READ) && pard_rise && sel_q && !fifo_empty;
    status_byte = {!fifo_empty, fifo_full, 2'b00, count_q};
    if (fifo_empty) begin
      head_byte = 8'h00;
    end else begin
      head_byte = mem_q[rd_ptr_q];
    end
  end

  assign bus.tx_ready = !fifo_full && !flush_cycle;

  // Next-state for the FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_cycle) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  // Bus access FSM with registered bus and receive outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      wr_byte_q  <= 8'h00;
      d_out_q    <= 8'h00;
      d_oe_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          d_oe_q <= 1'b0;
          // Read wins when both strobes fall together.
          if (pard_fall && addr_hit) begin
            state_q <= ST_READ;
            sel_q   <= addr_sel;
            d_oe_q  <= 1'b1;
            d_out_q <= addr_sel ? head_byte : status_byte;
          end else if (pawr_fall && addr_hit) begin
            state_q <= ST_WRITE;
            sel_q   <= addr_sel;
          end
        end
        ST_READ: begin
          // D_out is frozen here; the pop happens in the FIFO logic on this edge.
          if (pard_rise) begin
            d_oe_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (!pawr_s_q) begin
            wr_byte_q <= din_s_q;
          end
          if (pawr_rise) begin
            if (sel_q) begin
              rx_data_q  <= wr_byte_q;
              rx_valid_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          d_oe_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.D_out    = d_out_q;
  assign bus.D_oe     = d_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_snes_bus_respond.sv
// tb_snes_bus_respond
//   Directed bench for snes_bus_respond: reset state, status/data reads,
//   FIFO order and wrap, full FIFO, SNES writes, flush and reset mid-read.
module tb_snes_bus_respond;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  snes_bus_respond_if bus ();

  snes_bus_respond #(
    .BASE_ADDR  (8'hF8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // SNES read with latency checks on D_oe rising and falling.
  task automatic snes_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.PA = addr;
    @(negedge clk);
    bus.PARD_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk1({tag, "_oe_early"}, bus.D_oe, 1'b0);
    @(posedge clk);
    #1 chk1({tag, "_oe"}, bus.D_oe, 1'b1);
    chk8({tag, "_data"}, bus.D_out, exp);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.PARD_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk1({tag, "_oe_hold"}, bus.D_oe, 1'b1);
    chk8({tag, "_data_hold"}, bus.D_out, exp);
    @(posedge clk);
    #1 chk1({tag, "_oe_off"}, bus.D_oe, 1'b0);
    @(negedge clk);
    bus.PA = 8'h00;
  endtask

  // SNES write; optionally raises tx_valid exactly on the flush cycle.
  task automatic snes_write(input logic [7:0] addr, input logic [7:0] data,
                            input logic exp_pulse, input logic [7:0] exp_rx,
                            input logic push_on_rise, input string tag);
    @(negedge clk);
    bus.PA   = addr;
    bus.D_in = data;
    @(negedge clk);
    bus.PAWR_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk1({tag, "_oe_low"}, bus.D_oe, 1'b0);
    @(negedge clk);
    bus.PAWR_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk1({tag, "_rxv_early"}, bus.rx_valid, 1'b0);
    @(negedge clk);
    if (push_on_rise) begin
      bus.tx_data  = 8'hEE;
      bus.tx_valid = 1'b1;
      #1 chk1({tag, "_tx_ready_flush"}, bus.tx_ready, 1'b0);
    end
    @(posedge clk);
    #1 chk1({tag, "_rxv"}, bus.rx_valid, exp_pulse);
    chk8({tag, "_rx_data"}, bus.rx_data, exp_rx);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    @(posedge clk);
    #1 chk1({tag, "_rxv_after"}, bus.rx_valid, 1'b0);
    chk1({tag, "_oe_after"}, bus.D_oe, 1'b0);
    @(negedge clk);
    bus.PA   = 8'h00;
    bus.D_in = 8'h00;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.PA       = 8'h00;
    bus.PARD_n   = 1'b1;
    bus.PAWR_n   = 1'b1;
    bus.D_in     = 8'h00;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk1("rst_oe", bus.D_oe, 1'b0);
    chk8("rst_dout", bus.D_out, 8'h00);
    chk1("rst_tx_ready", bus.tx_ready, 1'b1);
    chk8("rst_rx_data", bus.rx_data, 8'h00);
    chk1("rst_rx_valid", bus.rx_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Status read of an empty FIFO
    snes_read(8'hF8, 8'h00, "stat_empty");

    // FIFO order and empty read
    push(8'h11);
    push(8'h22);
    push(8'h33);
    snes_read(8'hF8, 8'h83, "stat_3");
    snes_read(8'hF9, 8'h11, "rd_11");
    snes_read(8'hF9, 8'h22, "rd_22");
    snes_read(8'hF9, 8'h33, "rd_33");
    snes_read(8'hF9, 8'h00, "rd_empty");
    snes_read(8'hF8, 8'h00, "stat_after_empty");

    // Push/pop pairs carry the pointers across the wrap point
    for (int i = 0; i < 10; i++) begin
      push(8'h40 + 8'(i));
      snes_read(8'hF9, 8'h40 + 8'(i), "wrap");
    end

    // Full FIFO
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
    end
    #1 chk1("full_tx_ready", bus.tx_ready, 1'b0);
    snes_read(8'hF8, 8'hC8, "stat_full");
    push(8'h99);
    snes_read(8'hF8, 8'hC8, "stat_full_after_9th");
    snes_read(8'hF9, 8'h01, "rd_full_head");
    snes_read(8'hF8, 8'h87, "stat_7");
    chk1("tx_ready_7", bus.tx_ready, 1'b1);
    for (int i = 2; i <= 8; i++) begin
      snes_read(8'hF9, 8'(i), "drain");
    end
    snes_read(8'hF9, 8'h00, "drain_empty");

    // SNES writes
    snes_write(8'hF9, 8'hA5, 1'b1, 8'hA5, 1'b0, "wr_a5");
    snes_write(8'hF7, 8'h5A, 1'b0, 8'hA5, 1'b0, "wr_f7");
    snes_write(8'hFB, 8'h3C, 1'b0, 8'hA5, 1'b0, "wr_fb");
    snes_write(8'hF8, 8'h00, 1'b0, 8'hA5, 1'b0, "wr_ctrl0");

    // Flush with a push offered on the flush cycle
    for (int i = 0; i < 5; i++) begin
      push(8'hD0 + 8'(i));
    end
    snes_read(8'hF8, 8'h85, "stat_5");
    snes_write(8'hF8, 8'h01, 1'b0, 8'hA5, 1'b1, "flush");
    snes_read(8'hF8, 8'h00, "stat_flushed");
    snes_read(8'hF9, 8'h00, "rd_flushed");
    push(8'hC3);
    snes_read(8'hF9, 8'hC3, "rd_after_flush");

    // Reset in the middle of a data read
    push(8'hAB);
    @(negedge clk);
    bus.PA = 8'hF9;
    @(negedge clk);
    bus.PARD_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk1("midrst_oe_before", bus.D_oe, 1'b1);
    chk8("midrst_data", bus.D_out, 8'hAB);
    #3 rst_n = 1'b0;
    #1 chk1("midrst_oe_async", bus.D_oe, 1'b0);
    @(negedge clk);
    bus.PARD_n = 1'b1;
    bus.PA     = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk1("midrst_rx_valid", bus.rx_valid, 1'b0);
    chk1("midrst_tx_ready", bus.tx_ready, 1'b1);
    snes_read(8'hF8, 8'h00, "midrst_stat");
    snes_read(8'hF9, 8'h00, "midrst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
